// File: rtl/bus_pkg.sv
// Shared types and default decode tables for the bus wait-state decoder.
package bus_pkg;

  // Bus-cycle controller states
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE,
    ERR
  } bus_state_e;

  // Wait-state counter width
  localparam int unsigned WAIT_W = 4;
  // Width of a region index (up to 8 regions)
  localparam int unsigned IDX_W  = 3;

  // Default map: element 0 is region 0
  localparam logic [19:0] DEFAULT_BASE_ADDR [4] = '{20'h00000, 20'h80000, 20'h0FF00, 20'h01C00};
  localparam logic [19:0] DEFAULT_ADDR_MASK [4] = '{20'h80000, 20'h80000, 20'h0FFF0, 20'h0FE00};
  localparam logic [3:0]  DEFAULT_IS_IO          = 4'b1100;
  localparam logic [WAIT_W-1:0] DEFAULT_WAIT_STATES [4] = '{4'd0, 4'd1, 4'd2, 4'd5};

endpackage

// File: rtl/region_match.sv
// Combinational region decode: mask/compare every region and priority-encode
// the hits so the lowest region index wins.
module region_match
  import bus_pkg::*;
#(
  parameter int unsigned            NUM_REGIONS = 4,
  parameter int unsigned            ADDR_WIDTH  = 20,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR [NUM_REGIONS] = DEFAULT_BASE_ADDR,
  parameter logic [ADDR_WIDTH-1:0]  ADDR_MASK [NUM_REGIONS] = DEFAULT_ADDR_MASK,
  parameter logic [NUM_REGIONS-1:0] IS_IO = DEFAULT_IS_IO
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  iom_i,
  output logic                  hit_o,
  output logic [IDX_W-1:0]      hit_idx_o
);

  logic [NUM_REGIONS-1:0] match;

  // Per-region compare; the address space qualifier must agree with IOM
  always_comb begin
    for (int r = 0; r < int'(NUM_REGIONS); r++) begin
      match[r] = ((addr_i & ADDR_MASK[r]) == BASE_ADDR[r]) && (iom_i == IS_IO[r]);
    end
  end

  // Scan from the top down so the lowest matching index is the last written
  always_comb begin
    hit_o     = 1'b0;
    hit_idx_o = '0;
    for (int r = int'(NUM_REGIONS) - 1; r >= 0; r--) begin
      if (match[r]) begin
        hit_o     = 1'b1;
        hit_idx_o = IDX_W'(r);
      end
    end
  end

endmodule

// File: rtl/bus_wait_decoder.sv
// Address latch, region chip-select decode and wait-state generator for a
// multiplexed-address CPU bus.
module bus_wait_decoder
  import bus_pkg::*;
#(
  parameter int unsigned            NUM_REGIONS = 4,
  parameter int unsigned            ADDR_WIDTH  = 20,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR [NUM_REGIONS] = DEFAULT_BASE_ADDR,
  parameter logic [ADDR_WIDTH-1:0]  ADDR_MASK [NUM_REGIONS] = DEFAULT_ADDR_MASK,
  parameter logic [NUM_REGIONS-1:0] IS_IO = DEFAULT_IS_IO,
  parameter logic [WAIT_W-1:0]      WAIT_STATES [NUM_REGIONS] = DEFAULT_WAIT_STATES
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  ALE,
  input  logic                  IOM,
  input  logic                  RD,
  input  logic                  WR,
  input  logic [7:0]            AD,
  input  logic [ADDR_WIDTH-9:0] A,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [NUM_REGIONS-1:0] CS,
  output logic                  READY,
  output logic                  DECODE_ERR
);

  bus_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [NUM_REGIONS-1:0] cs_q, cs_d;
  logic [WAIT_W-1:0]      cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic                   hit;
  logic [IDX_W-1:0]       hit_idx;
  logic [NUM_REGIONS-1:0] hit_onehot;
  logic [WAIT_W-1:0]      hit_wait;
  logic                   rd_act, wr_act;

  assign rd_act = ~RD;
  assign wr_act = ~WR;

  region_match #(
    .NUM_REGIONS (NUM_REGIONS),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .BASE_ADDR   (BASE_ADDR),
    .ADDR_MASK   (ADDR_MASK),
    .IS_IO       (IS_IO)
  ) u_region_match (
    .addr_i    (addr_q),
    .iom_i     (IOM),
    .hit_o     (hit),
    .hit_idx_o (hit_idx)
  );

  // Expand the winning index into a chip-select vector and look up its wait count
  always_comb begin
    hit_onehot = '0;
    hit_wait   = '0;
    for (int r = 0; r < int'(NUM_REGIONS); r++) begin
      if (hit_idx == IDX_W'(r)) begin
        hit_onehot[r] = 1'b1;
        hit_wait      = WAIT_STATES[r];
      end
    end
  end

  // Next-state logic for the address latch, bus-cycle FSM, counter and error pulse
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cs_d    = cs_q;
    err_d   = 1'b0;
    // The latched address is frozen while a wait sequence is running
    addr_d  = (ALE && (state_q != WAIT)) ? {A, AD} : addr_q;

    unique case (state_q)
      IDLE: begin
        if (rd_act && wr_act) begin
          state_d = ERR;
          err_d   = 1'b1;
          cs_d    = '0;
        end else if (rd_act || wr_act) begin
          if (hit) begin
            cs_d    = hit_onehot;
            cnt_d   = hit_wait;
            state_d = (hit_wait != '0) ? WAIT : DONE;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
            cs_d    = '0;
          end
        end
      end
      WAIT: begin
        if (!rd_act && !wr_act) begin
          // Strobe withdrawn early: abandon the cycle
          state_d = IDLE;
          cs_d    = '0;
          cnt_d   = '0;
        end else if (cnt_q <= WAIT_W'(1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end
      DONE: begin
        if (!rd_act && !wr_act) begin
          state_d = IDLE;
          cs_d    = '0;
        end
      end
      ERR: begin
        cs_d = '0;
        if (!rd_act && !wr_act) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cs_d    = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cs_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cs_q    <= cs_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // READY follows the state directly so a reset releases it without a clock
  assign READY      = (state_q != WAIT);
  assign Address    = addr_q;
  assign CS         = cs_q;
  assign DECODE_ERR = err_q;

endmodule

// File: tb/tb_bus_wait_decoder.sv
// Directed self-checking bench for bus_wait_decoder with default parameters.
module tb_bus_wait_decoder;

  logic        CLK;
  logic        RESET;
  logic        ALE;
  logic        IOM;
  logic        RD;
  logic        WR;
  logic [7:0]  AD;
  logic [11:0] A;
  logic [19:0] Address;
  logic [3:0]  CS;
  logic        READY;
  logic        DECODE_ERR;

  int n_checks;
  int n_fail;

  bus_wait_decoder dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .ALE        (ALE),
    .IOM        (IOM),
    .RD         (RD),
    .WR         (WR),
    .AD         (AD),
    .A          (A),
    .Address    (Address),
    .CS         (CS),
    .READY      (READY),
    .DECODE_ERR (DECODE_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one clock; sample point is 1 time unit after the edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Address phase: present the address with ALE for one clock
  task automatic addr_phase(input logic [19:0] addr, input logic iom);
    ALE = 1'b1;
    A   = addr[19:8];
    AD  = addr[7:0];
    IOM = iom;
    RD  = 1'b1;
    WR  = 1'b1;
    tick();
    ALE = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    ALE = 1'b0; IOM = 1'b0; RD = 1'b1; WR = 1'b1; AD = 8'h00; A = 12'h000;
    tick();
    n_checks++;
    if (Address !== 20'h00000) begin n_fail++; $display("FAIL reset_addr: got %h want %h", Address, 20'h00000); end
    n_checks++;
    if (CS !== 4'b0000) begin n_fail++; $display("FAIL reset_cs: got %b want %b", CS, 4'b0000); end
    n_checks++;
    if (READY !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", READY); end
    n_checks++;
    if (DECODE_ERR !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", DECODE_ERR); end
    RESET = 1'b0;
    tick();
  endtask

  // Region 0, memory, zero wait states
  task automatic test_zero_wait();
    int low;
    int errs;
    low = 0;
    errs = 0;
    addr_phase(20'h12345, 1'b0);
    n_checks++;
    if (Address !== 20'h12345) begin n_fail++; $display("FAIL zw_addr: got %h want %h", Address, 20'h12345); end
    RD = 1'b0;
    tick();
    n_checks++;
    if (CS !== 4'b0001) begin n_fail++; $display("FAIL zw_cs: got %b want %b", CS, 4'b0001); end
    for (int i = 0; i < 4; i++) begin
      if (READY !== 1'b1) low++;
      if (DECODE_ERR !== 1'b0) errs++;
      tick();
    end
    n_checks++;
    if (low != 0) begin n_fail++; $display("FAIL zw_ready_low: got %0d cycles want 0", low); end
    n_checks++;
    if (errs != 0) begin n_fail++; $display("FAIL zw_decode_err: got %0d cycles want 0", errs); end
    RD = 1'b1;
    tick();
    n_checks++;
    if (CS !== 4'b0000) begin n_fail++; $display("FAIL zw_cs_release: got %b want %b", CS, 4'b0000); end
  endtask

  // Region 2, I/O write, two wait states; bus noise during WAIT must not matter
  task automatic test_io_wait2();
    int low;
    addr_phase(20'h0FF07, 1'b1);
    WR = 1'b0;
    tick();
    n_checks++;
    if (CS !== 4'b0100) begin n_fail++; $display("FAIL w2_cs: got %b want %b", CS, 4'b0100); end
    // Disturb the bus while waiting
    ALE = 1'b1; A = 12'hABC; AD = 8'h55; IOM = 1'b0;
    low = 0;
    for (int i = 0; i < 10 && READY === 1'b0; i++) begin
      low++;
      tick();
      ALE = 1'b0;
    end
    n_checks++;
    if (low != 2) begin n_fail++; $display("FAIL w2_ready_low: got %0d cycles want 2", low); end
    n_checks++;
    if (Address !== 20'h0FF07) begin n_fail++; $display("FAIL w2_addr_hold: got %h want %h", Address, 20'h0FF07); end
    n_checks++;
    if (CS !== 4'b0100) begin n_fail++; $display("FAIL w2_cs_done: got %b want %b", CS, 4'b0100); end
    tick();
    tick();
    n_checks++;
    if (READY !== 1'b1 || CS !== 4'b0100) begin
      n_fail++; $display("FAIL w2_done_hold: got ready=%b cs=%b want ready=1 cs=0100", READY, CS);
    end
    WR = 1'b1;
    tick();
    n_checks++;
    if (CS !== 4'b0000) begin n_fail++; $display("FAIL w2_cs_release: got %b want %b", CS, 4'b0000); end
  endtask

  // Region 3, five wait states, reset pulsed in the third wait cycle
  task automatic test_reset_mid_wait();
    int low;
    addr_phase(20'h01D00, 1'b1);
    RD = 1'b0;
    tick();
    n_checks++;
    if (CS !== 4'b1000 || READY !== 1'b0) begin
      n_fail++; $display("FAIL rw_start: got cs=%b ready=%b want cs=1000 ready=0", CS, READY);
    end
    tick();
    tick();
    n_checks++;
    if (READY !== 1'b0) begin n_fail++; $display("FAIL rw_cycle3: got ready=%b want 0", READY); end
    #2;
    RESET = 1'b1;
    #1;
    n_checks++;
    if (READY !== 1'b1) begin n_fail++; $display("FAIL rw_async_ready: got %b want 1", READY); end
    n_checks++;
    if (CS !== 4'b0000) begin n_fail++; $display("FAIL rw_async_cs: got %b want %b", CS, 4'b0000); end
    RESET = 1'b0;
    RD = 1'b1;
    tick();
    // First cycle after reset: region 1, one wait state
    addr_phase(20'h80004, 1'b0);
    RD = 1'b0;
    tick();
    n_checks++;
    if (CS !== 4'b0010) begin n_fail++; $display("FAIL rw_post_cs: got %b want %b", CS, 4'b0010); end
    low = 0;
    for (int i = 0; i < 10 && READY === 1'b0; i++) begin
      low++;
      tick();
    end
    n_checks++;
    if (low != 1) begin n_fail++; $display("FAIL rw_post_ready_low: got %0d cycles want 1", low); end
    RD = 1'b1;
    tick();
  endtask

  // I/O read to an unmapped address
  task automatic test_unmapped();
    int pulses;
    addr_phase(20'h03000, 1'b1);
    RD = 1'b0;
    tick();
    n_checks++;
    if (DECODE_ERR !== 1'b1) begin n_fail++; $display("FAIL um_err: got %b want 1", DECODE_ERR); end
    n_checks++;
    if (CS !== 4'b0000 || READY !== 1'b1) begin
      n_fail++; $display("FAIL um_cs_ready: got cs=%b ready=%b want cs=0000 ready=1", CS, READY);
    end
    pulses = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (DECODE_ERR === 1'b1) pulses++;
    end
    RD = 1'b1;
    tick();
    if (DECODE_ERR === 1'b1) pulses++;
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL um_pulses: got %0d want 1", pulses); end
  endtask

  // Both strobes low at a mapped address
  task automatic test_both_strobes();
    int pulses;
    int cs_bad;
    addr_phase(20'h80000, 1'b0);
    RD = 1'b0;
    WR = 1'b0;
    pulses = 0;
    cs_bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (DECODE_ERR === 1'b1) pulses++;
      if (CS !== 4'b0000) cs_bad++;
    end
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL bs_pulses: got %0d want 1", pulses); end
    n_checks++;
    if (cs_bad != 0) begin n_fail++; $display("FAIL bs_cs: got %0d cycles with cs set want 0", cs_bad); end
    RD = 1'b1;
    WR = 1'b1;
    tick();
  endtask

  // Region 1 read withdrawn during the single wait cycle
  task automatic test_abort();
    addr_phase(20'h80010, 1'b0);
    RD = 1'b0;
    tick();
    n_checks++;
    if (CS !== 4'b0010 || READY !== 1'b0) begin
      n_fail++; $display("FAIL ab_start: got cs=%b ready=%b want cs=0010 ready=0", CS, READY);
    end
    RD = 1'b1;
    tick();
    n_checks++;
    if (READY !== 1'b1 || CS !== 4'b0000) begin
      n_fail++; $display("FAIL ab_release: got cs=%b ready=%b want cs=0000 ready=1", CS, READY);
    end
    tick();
    n_checks++;
    if (CS !== 4'b0000 || DECODE_ERR !== 1'b0) begin
      n_fail++; $display("FAIL ab_idle: got cs=%b err=%b want cs=0000 err=0", CS, DECODE_ERR);
    end
    // A fresh cycle starts cleanly from IDLE
    addr_phase(20'h12345, 1'b0);
    RD = 1'b0;
    tick();
    n_checks++;
    if (CS !== 4'b0001 || READY !== 1'b1) begin
      n_fail++; $display("FAIL ab_next: got cs=%b ready=%b want cs=0001 ready=1", CS, READY);
    end
    RD = 1'b1;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_zero_wait();
    test_io_wait2();
    test_reset_mid_wait();
    test_unmapped();
    test_both_strobes();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
